// File: rtl/hb_interp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hb_interp_pkg : shared constants, coefficient ROM and FSM states for the
//                 halfband 2x interpolator.            Rev 1.0
// ---------------------------------------------------------------------------
package hb_interp_pkg;

  localparam int c_width_dflt  = 16;
  localparam int c_cwidth_dflt = 18;
  localparam int c_accw_dflt   = 40;
  localparam int c_ntaps       = 8;
  localparam int c_nbuf        = 16;

  // Q1.17 half-length coefficient set; taps i and 15-i share c[i]
  localparam logic signed [c_cwidth_dflt-1:0] c_coef [0:c_ntaps-1] = '{
    -18'sd64, 18'sd192, -18'sd480, 18'sd1024,
    -18'sd1984, 18'sd3712, -18'sd7168, 18'sd70304
  };

  localparam int c_rnd = 65536;

  // Three flush cycles line OUT up with the final accumulate at edge 12
  localparam logic [2:0] c_mac_last   = 3'd7;
  localparam logic [2:0] c_drain_last = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CENTER = 3'd1,
    S_MAC    = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/halfband_interp_preadd_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// preadd_mac : 4-stage operand register / pre-add / multiply / accumulate
//              pipeline for the symmetric halfband taps.   Rev 1.0
// ---------------------------------------------------------------------------
module preadd_mac
  import hb_interp_pkg::*;
#(
  parameter int WIDTH  = c_width_dflt,
  parameter int CWIDTH = c_cwidth_dflt,
  parameter int ACCW   = c_accw_dflt
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic signed [WIDTH-1:0]  i_a,
  input  logic signed [WIDTH-1:0]  i_b,
  input  logic signed [CWIDTH-1:0] i_coef,
  input  logic                     i_valid,
  input  logic                     i_first,
  output logic signed [ACCW-1:0]   o_acc
);

  localparam int c_pw = WIDTH + 1;
  localparam int c_mw = c_pw + CWIDTH;

  logic signed [WIDTH-1:0]  r_a, r_b;
  logic signed [CWIDTH-1:0] r_coef1, r_coef2;
  logic signed [c_pw-1:0]   r_pre;
  logic signed [c_mw-1:0]   r_prod;
  logic signed [ACCW-1:0]   r_acc;
  logic                     r_v1, r_v2, r_v3;
  logic                     r_f1, r_f2, r_f3;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_coef1 <= '0;
      r_coef2 <= '0;
      r_pre   <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_f1    <= 1'b0;
      r_f2    <= 1'b0;
      r_f3    <= 1'b0;
    end else if (i_clear) begin
      r_a     <= '0;
      r_b     <= '0;
      r_coef1 <= '0;
      r_coef2 <= '0;
      r_pre   <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_f1    <= 1'b0;
      r_f2    <= 1'b0;
      r_f3    <= 1'b0;
    end else begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_coef1 <= i_coef;
      r_v1    <= i_valid;
      r_f1    <= i_valid & i_first;
      r_pre   <= c_pw'(r_a) + c_pw'(r_b);
      r_coef2 <= r_coef1;
      r_v2    <= r_v1;
      r_f2    <= r_f1;
      r_prod  <= c_mw'(r_pre) * c_mw'(r_coef2);
      r_v3    <= r_v2;
      r_f3    <= r_f2;
      // The first pair of a sample restarts the sum instead of adding to it
      if (r_v3) r_acc <= r_f3 ? ACCW'(r_prod) : r_acc + ACCW'(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/halfband_interp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// halfband_interp : halfband 2x interpolator, one sample in, center tap then
//                   filtered sample out.                   Rev 1.0
// ---------------------------------------------------------------------------
module halfband_interp
  import hb_interp_pkg::*;
#(
  parameter int WIDTH  = c_width_dflt,
  parameter int CWIDTH = c_cwidth_dflt,
  parameter int ACCW   = c_accw_dflt
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_clear,
  input  logic                    i_strobe_in,
  input  logic signed [WIDTH-1:0] i_sample_in,
  output logic                    o_strobe_out,
  output logic signed [WIDTH-1:0] o_sample_out,
  output logic                    o_overrun
);

  state_t                   r_state, w_next;
  logic [2:0]               r_cnt;
  logic signed [WIDTH-1:0]  r_buf [c_nbuf];
  logic                     r_strobe, r_overrun;
  logic signed [WIDTH-1:0]  r_sample;

  logic                     w_busy, w_accept, w_ovf;
  logic signed [WIDTH-1:0]  w_a, w_b, w_sat;
  logic signed [CWIDTH-1:0] w_coef;
  logic signed [ACCW-1:0]   w_acc, w_rnd, w_shift;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = i_strobe_in & i_enable & ~w_busy & ~i_clear;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CENTER;
      S_CENTER: w_next = S_MAC;
      S_MAC:    if (r_cnt == c_mac_last) w_next = S_DRAIN;
      S_DRAIN:  if (r_cnt == c_drain_last) w_next = S_OUT;
      S_OUT:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (i_clear) w_next = S_IDLE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 3'd1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < c_nbuf; k++) r_buf[k] <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < c_nbuf; k++) r_buf[k] <= '0;
    end else if (w_accept) begin
      r_buf[0] <= i_sample_in;
      for (int k = 1; k < c_nbuf; k++) r_buf[k] <= r_buf[k-1];
    end
  end

  // Pair i of the symmetric fold: x[n-i] + x[n-15+i]
  assign w_a    = r_buf[r_cnt];
  assign w_b    = r_buf[4'd15 - {1'b0, r_cnt}];
  assign w_coef = CWIDTH'(c_coef[r_cnt]);

  preadd_mac #(
    .WIDTH  (WIDTH),
    .CWIDTH (CWIDTH),
    .ACCW   (ACCW)
  ) u_mac (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_coef  (w_coef),
    .i_valid (r_state == S_MAC),
    .i_first (r_cnt == 3'd0),
    .o_acc   (w_acc)
  );

  assign w_rnd   = w_acc + ACCW'(c_rnd);
  assign w_shift = w_rnd >>> (CWIDTH - 1);
  assign w_ovf   = ~((&w_shift[ACCW-1:WIDTH-1]) | ~(|w_shift[ACCW-1:WIDTH-1]));

  always_comb begin
    w_sat = w_shift[WIDTH-1:0];
    if (w_ovf) w_sat = w_shift[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_strobe  <= 1'b0;
      r_sample  <= '0;
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_strobe  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_state == S_CENTER) begin
        r_strobe <= 1'b1;
        r_sample <= r_buf[7];
      end else if (r_state == S_OUT) begin
        r_strobe <= 1'b1;
        r_sample <= w_sat;
      end
      if (i_strobe_in & i_enable & w_busy) r_overrun <= 1'b1;
    end
  end

  assign o_strobe_out = r_strobe;
  assign o_sample_out = r_sample;
  assign o_overrun    = r_overrun;

endmodule
`default_nettype wire
